// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the slave mux.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers.
// With AHB_MUX_TIMEOUT_EN it also aborts a stalled real slave after TIMEOUT_CYC wait cycles.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic hready,
  input  logic unmapped_req,
`ifdef AHB_MUX_TIMEOUT_EN
  input  logic slave_stall,
  output logic timeout,
`endif
  output logic err_ready,
  output logic err_resp,
  output logic err_busy
);

  ds_state_t state;
  logic      tmo_hit;

`ifdef AHB_MUX_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // The hit fires on the last permitted wait cycle so the ERROR starts right after it.
  assign tmo_hit = (state == DS_OKAY) && slave_stall &&
                   (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (hready)
        wait_cnt <= '0;
      else if (slave_stall && state == DS_OKAY)
        wait_cnt <= wait_cnt + 16'd1;
      if (tmo_hit)
        timeout <= 1'b1;
    end
  end
`else
  logic [15:0] unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = 16'(TIMEOUT_CYC);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DS_OKAY;
      err_ready <= 1'b1;
      err_resp  <= HRESP_OKAY;
      err_busy  <= 1'b0;
    end else begin
      case (state)
        DS_OKAY: begin
          if ((hready && unmapped_req) || tmo_hit) begin
            state     <= DS_ERR1;
            err_ready <= 1'b0;
            err_resp  <= HRESP_ERROR;
            err_busy  <= 1'b1;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          err_ready <= 1'b1;
          err_resp  <= HRESP_ERROR;
          err_busy  <= 1'b1;
        end
        DS_ERR2: begin
          if (unmapped_req) begin
            state     <= DS_ERR1;
            err_ready <= 1'b0;
            err_resp  <= HRESP_ERROR;
            err_busy  <= 1'b1;
          end else begin
            state     <= DS_OKAY;
            err_ready <= 1'b1;
            err_resp  <= HRESP_OKAY;
            err_busy  <= 1'b0;
          end
        end
        default: begin
          state     <= DS_OKAY;
          err_ready <= 1'b1;
          err_resp  <= HRESP_OKAY;
          err_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite address decoder and data-phase response mux with a built-in default slave.
// Optional wait-state timeout enabled by defining AHB_MUX_TIMEOUT_EN.
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int NSLV        = 4,
  parameter int SEL_MSB     = 31,
  parameter int SEL_LSB     = 28,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic [NSLV-1:0]      HSEL_S,
  input  logic [NSLV*32-1:0]   HRDATA_S,
  input  logic [NSLV-1:0]      HREADYOUT_S,
  input  logic [NSLV-1:0]      HRESP_S,
  output logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HRESP
`ifdef AHB_MUX_TIMEOUT_EN
  ,
  output logic                 TIMEOUT
`endif
);

  localparam int RW = SEL_MSB - SEL_LSB + 1;

  logic [RW-1:0] region;
  logic          mapped;
  logic          active;
  logic          unmapped_req;
  logic [NSLV:0] dp_sel;
  logic [31:0]   slave_data;
  logic          slave_ready;
  logic          slave_resp;
  logic          err_ready;
  logic          err_resp;
  logic          err_busy;
  logic          unused_bits;

  assign region       = HADDR[SEL_MSB:SEL_LSB];
  assign mapped       = int'(region) < NSLV;
  assign active       = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign unmapped_req = ~mapped & active;
  assign unused_bits  = ^{HADDR, dp_sel[NSLV]};

  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NSLV; i++)
      HSEL_S[i] = (int'(region) == i);
  end

  // The MSB marks the default slave; all-zero means nothing owns the data phase yet.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      dp_sel <= '0;
    else if (HREADY)
      dp_sel <= {~mapped, HSEL_S};
  end

  always_comb begin
    slave_data  = '0;
    slave_ready = 1'b1;
    slave_resp  = HRESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      if (dp_sel[i]) begin
        slave_data  = HRDATA_S[32*i +: 32];
        slave_ready = HREADYOUT_S[i];
        slave_resp  = HRESP_S[i];
      end
    end
  end

  // While the default slave runs an ERROR sequence it overrides whichever owner is registered.
  assign HREADY = err_busy ? err_ready : slave_ready;
  assign HRESP  = err_busy ? err_resp  : slave_resp;
  assign HRDATA = slave_data;

`ifdef AHB_MUX_TIMEOUT_EN
  logic slave_stall;
  assign slave_stall = (|dp_sel[NSLV-1:0]) & ~slave_ready;
`endif

  ahb_default_slave #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_default_slave (
    .clk          (HCLK),
    .rst          (HRESET),
    .hready       (HREADY),
    .unmapped_req (unmapped_req),
`ifdef AHB_MUX_TIMEOUT_EN
    .slave_stall  (slave_stall),
    .timeout      (TIMEOUT),
`endif
    .err_ready    (err_ready),
    .err_resp     (err_resp),
    .err_busy     (err_busy)
  );

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Scoreboard bench for ahb_slave_mux: randomized transfers against a transfer-level model.
module tb_ahb_slave_mux;
  import ahb_pkg::*;

  localparam int NSLV = 4;
  localparam int TCYC = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic [NSLV-1:0]    HSEL_S;
  logic [NSLV*32-1:0] HRDATA_S;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV-1:0]    HRESP_S;
  logic               HREADY;
  logic [31:0]        HRDATA;
  logic               HRESP;
`ifdef AHB_MUX_TIMEOUT_EN
  logic               TIMEOUT;
`endif

  always #5 clk = ~clk;

  ahb_slave_mux #(
    .NSLV(NSLV), .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT_CYC(TCYC)
  ) dut (
    .HCLK(clk), .HRESET(rst), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL_S(HSEL_S),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
`ifdef AHB_MUX_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    int          waits;
    logic [31:0] data;
    logic        resp;
    logic        tmo;
  } xfer_t;

  // One data phase as seen by the master: len cycles, the last one completing.
  typedef struct {
    int          len;
    logic        err;
    logic        tmo;
    logic        resp;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t            sb[$];
  int              vectors = 0;
  int              miscompares = 0;
  logic [NSLV-1:0] exp_hsel = '0;
  logic            exp_timeout = 1'b0;
  logic            mon_en = 1'b0;

  xfer_t prev;
  int    prev_owner;
  int    prev_len;
  xfer_t x;
  exp_t  e_none;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    return int'(a[31:28]);
  endfunction

  function automatic logic [NSLV-1:0] hsel_of(input logic [31:0] a);
    logic [NSLV-1:0] h;
    h = '0;
    if (region_of(a) < NSLV) h[region_of(a)] = 1'b1;
    return h;
  endfunction

  function automatic exp_t expect_of(input xfer_t t);
    exp_t e;
    e.len = 1; e.err = 1'b0; e.tmo = 1'b0; e.resp = 1'b0; e.data = '0; e.chk_data = 1'b1;
    if (region_of(t.addr) < NSLV) begin
      if (t.tmo) begin
        e.len = TCYC + 2; e.err = 1'b1; e.tmo = 1'b1; e.resp = 1'b1; e.chk_data = 1'b0;
      end else begin
        e.len = t.waits + 1; e.resp = t.resp; e.data = t.data;
      end
    end else if (t.trans == HTRANS_NONSEQ || t.trans == HTRANS_SEQ) begin
      e.len = 2; e.err = 1'b1; e.resp = 1'b1;
    end
    return e;
  endfunction

  // The owning slave follows its programmed wait count; everyone else drives noise.
  task automatic drive_slaves(input int c);
    for (int i = 0; i < NSLV; i++) begin
      if (i == prev_owner && !prev.tmo && c == prev.waits) begin
        HREADYOUT_S[i]        = 1'b1;
        HRESP_S[i]            = prev.resp;
        HRDATA_S[32*i +: 32]  = prev.data;
      end else if (i == prev_owner) begin
        HREADYOUT_S[i]        = 1'b0;
        HRESP_S[i]            = 1'b0;
        HRDATA_S[32*i +: 32]  = $urandom;
      end else begin
        HREADYOUT_S[i]        = 1'($urandom_range(0, 1));
        HRESP_S[i]            = 1'($urandom_range(0, 1));
        HRDATA_S[32*i +: 32]  = $urandom;
      end
    end
  endtask

  // Present the next address while the previous transfer's data phase plays out.
  task automatic applyStimulus(input xfer_t nxt);
    HADDR    = nxt.addr;
    HTRANS   = nxt.trans;
    exp_hsel = hsel_of(nxt.addr);
    sb.push_back(expect_of(nxt));
    for (int c = 0; c < prev_len; c++) begin
      drive_slaves(c);
      @(posedge clk); #1;
    end
    prev       = nxt;
    prev_len   = expect_of(nxt).len;
    prev_owner = (region_of(nxt.addr) < NSLV) ? region_of(nxt.addr) : -1;
  endtask

  function automatic xfer_t mk(input logic [31:0] a, input logic [1:0] t, input int w,
                               input logic [31:0] d, input logic r, input logic tm);
    xfer_t v;
    v.addr = a; v.trans = t; v.waits = w; v.data = d; v.resp = r; v.tmo = tm;
    return v;
  endfunction

  int   mk_k = 0;
  exp_t mon_e;
  logic mon_rdy;
  logic mon_rsp;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checkOutput("hsel", 32'(HSEL_S), 32'(exp_hsel));
      if (sb.size() > 0) begin
        mon_e = sb[0];
        if (mon_e.err && mk_k == mon_e.len - 2) begin
          mon_rdy = 1'b0; mon_rsp = 1'b1;
          if (mon_e.tmo) exp_timeout = 1'b1;
        end else if (mk_k == mon_e.len - 1) begin
          mon_rdy = 1'b1; mon_rsp = mon_e.resp;
        end else begin
          mon_rdy = 1'b0; mon_rsp = 1'b0;
        end
        checkOutput("hready", 32'(HREADY), 32'(mon_rdy));
        checkOutput("hresp", 32'(HRESP), 32'(mon_rsp));
        if (mk_k == mon_e.len - 1 && mon_e.chk_data)
          checkOutput("hrdata", HRDATA, mon_e.data);
        if (mk_k == mon_e.len - 1) begin
          void'(sb.pop_front());
          mk_k = 0;
        end else begin
          mk_k++;
        end
      end
`ifdef AHB_MUX_TIMEOUT_EN
      checkOutput("timeout", 32'(TIMEOUT), 32'(exp_timeout));
`endif
    end
  end

  initial begin
    HADDR       = 32'hF000_0000;
    HTRANS      = HTRANS_IDLE;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hready", 32'(HREADY), 32'd1);
    checkOutput("rst_hresp", 32'(HRESP), 32'd0);
    checkOutput("rst_hrdata", HRDATA, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    prev       = mk(32'hF000_0000, HTRANS_IDLE, 0, 32'd0, 1'b0, 1'b0);
    prev_owner = -1;
    prev_len   = 1;
    e_none     = expect_of(prev);
    sb.push_back(e_none);
    mon_en     = 1'b1;

    applyStimulus(mk(32'h1000_0004, HTRANS_NONSEQ, 0, $urandom, 1'b0, 1'b0));
    applyStimulus(mk(32'h2000_0000, HTRANS_NONSEQ, 0, 32'hA5A5_0F0F, 1'b0, 1'b0));
    applyStimulus(mk(32'h7000_0000, HTRANS_IDLE, 0, 32'd0, 1'b0, 1'b0));
    applyStimulus(mk(32'h7000_0000, HTRANS_NONSEQ, 0, 32'd0, 1'b0, 1'b0));
    applyStimulus(mk(32'h7000_0000, HTRANS_SEQ, 0, 32'd0, 1'b0, 1'b0));
    applyStimulus(mk(32'h0000_0010, HTRANS_NONSEQ, 3, $urandom, 1'b0, 1'b0));
    applyStimulus(mk(32'h1000_0020, HTRANS_SEQ, 1, $urandom, 1'b0, 1'b0));
    applyStimulus(mk(32'h3000_0000, HTRANS_NONSEQ, 0, $urandom, 1'b1, 1'b0));
`ifdef AHB_MUX_TIMEOUT_EN
    applyStimulus(mk(32'h3000_0040, HTRANS_NONSEQ, 0, 32'd0, 1'b0, 1'b1));
    applyStimulus(mk(32'h7000_0000, HTRANS_NONSEQ, 0, 32'd0, 1'b0, 1'b0));
`endif

    for (int n = 0; n < 80; n++) begin
      x.addr  = $urandom;
      x.addr[31:28] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, NSLV - 1))
                                                  : 4'($urandom_range(NSLV, 15));
      x.trans = 2'($urandom_range(0, 3));
      x.waits = $urandom_range(0, 3);
      x.data  = $urandom;
      x.resp  = ($urandom_range(0, 7) == 0);
      x.tmo   = 1'b0;
      applyStimulus(x);
    end
    applyStimulus(mk(32'hF000_0000, HTRANS_IDLE, 0, 32'd0, 1'b0, 1'b0));

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    #1;
    checkOutput("drain", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;

    // Reset while slave 1 is stalling must release the bus immediately.
    HADDR       = 32'h1000_0000;
    HTRANS      = HTRANS_NONSEQ;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    @(posedge clk); #1;
    HADDR       = 32'hF000_0000;
    HTRANS      = HTRANS_IDLE;
    HREADYOUT_S = '0;
    HRDATA_S    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    #1;
    checkOutput("stall_hready", 32'(HREADY), 32'd0);
    checkOutput("stall_hrdata", HRDATA, 32'h2222_2222);
    rst = 1'b1;
    #1;
    checkOutput("arst_hready", 32'(HREADY), 32'd1);
    checkOutput("arst_hresp", 32'(HRESP), 32'd0);
    checkOutput("arst_hrdata", HRDATA, 32'd0);
`ifdef AHB_MUX_TIMEOUT_EN
    checkOutput("arst_timeout", 32'(TIMEOUT), 32'd0);
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
